// File: rtl/turn_pkg.sv
// Shared types and helpers for the tail-light turn sequencer.
// Latency: none (types and a pure combinational function only).
// Backpressure: none; nothing here holds state.
package turn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEFT,
        RIGHT,
        HAZARD,
        LOCKOUT
    } turn_state_t;

    // Widest lamp bank the fill helper can describe.
    localparam int MAX_LAMPS = 32;

    // Pattern with k lamps lit out of n.
    // LSB-first fills from bit 0 upward; MSB-first fills from bit n-1 downward.
    function automatic logic [MAX_LAMPS-1:0] fill_pattern(
        input int unsigned k,
        input int unsigned n,
        input logic        msb_first
    );
        logic [MAX_LAMPS-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < MAX_LAMPS; i++) begin
            if (msb_first) begin
                p[i] = (i < n) && (i + k >= n);
            end else begin
                p[i] = (i < k);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Step prescaler: pulses tick once every TICK_DIV clocks, restartable.
// Latency: tick is combinational from the counter; restart clears it the same edge.
// Backpressure: none; free-running apart from restart.
module tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    // A restart suppresses the pulse so the new sequence gets a full period.
    assign tick = !restart && (cnt_q == LAST);

    // Count up, wrapping to zero on the pulse or on a restart.
    always_comb begin
        cnt_d = cnt_q;
        if (restart || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PW'(1);
        end
    end

    // Prescaler register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/turn_sequencer.sv
// Tail-light sequencer: turn fill, hazard flash, brake overlay, both-switch lockout.
// Latency: one clock from input sample to registered lamp/error outputs.
// Backpressure: none; inputs are levels sampled every clock.
module turn_sequencer
    import turn_pkg::*;
#(
    parameter int LAMPS    = 3,
    parameter int TICK_DIV = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             left,
    input  logic             right,
    input  logic             hazard,
    input  logic             brake,
    output logic [LAMPS-1:0] l_signal,
    output logic [LAMPS-1:0] r_signal,
    output logic             error
);

    localparam int SW = $clog2(LAMPS + 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(LAMPS);
    localparam logic [SW-1:0] STEP_ONE  = SW'(1);

    turn_state_t      state_q, state_d;
    logic [SW-1:0]    step_q, step_d;
    logic [LAMPS-1:0] l_q, l_d;
    logic [LAMPS-1:0] r_q, r_d;
    logic             err_q, err_d;
    logic             entering;
    logic             tick;

    // Any state change restarts pacing so a new pattern holds for a full step.
    assign entering = (state_d != state_q);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clock   (clock),
        .reset_n (reset_n),
        .restart (entering),
        .tick    (tick)
    );

    // Next state by input priority; lockout holds until both turn switches drop.
    always_comb begin
        state_d = IDLE;
        if (left && right) begin
            state_d = LOCKOUT;
        end else if ((state_q == LOCKOUT) && (left || right)) begin
            state_d = LOCKOUT;
        end else if (hazard) begin
            state_d = HAZARD;
        end else if (left) begin
            state_d = LEFT;
        end else if (right) begin
            state_d = RIGHT;
        end
    end

    // Step counter: fill position for turns, on/off phase (non-zero = on) for hazard.
    always_comb begin
        step_d = '0;
        case (state_d)
            LEFT, RIGHT: begin
                if (entering) begin
                    step_d = STEP_ONE;
                end else if (tick) begin
                    step_d = (step_q == STEP_LAST) ? '0 : step_q + STEP_ONE;
                end else begin
                    step_d = step_q;
                end
            end
            HAZARD: begin
                if (entering) begin
                    step_d = STEP_ONE;
                end else if (tick) begin
                    step_d = (step_q == '0) ? STEP_ONE : '0;
                end else begin
                    step_d = step_q;
                end
            end
            default: step_d = '0;
        endcase
    end

    // Lamp and error outputs from the upcoming state and step, with brake overlay.
    always_comb begin
        l_d   = '0;
        r_d   = '0;
        err_d = 1'b0;
        case (state_d)
            IDLE: begin
                if (brake) begin
                    l_d = '1;
                    r_d = '1;
                end
            end
            LEFT: begin
                l_d = LAMPS'(fill_pattern(32'(step_d), 32'(LAMPS), 1'b0));
                if (brake) r_d = '1;
            end
            RIGHT: begin
                r_d = LAMPS'(fill_pattern(32'(step_d), 32'(LAMPS), 1'b1));
                if (brake) l_d = '1;
            end
            HAZARD: begin
                if (step_d != '0) begin
                    l_d = '1;
                    r_d = '1;
                end
            end
            LOCKOUT: err_d = 1'b1;
            default: err_d = 1'b0;
        endcase
    end

    // State, step and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            l_q     <= '0;
            r_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            l_q     <= l_d;
            r_q     <= r_d;
            err_q   <= err_d;
        end
    end

    assign l_signal = l_q;
    assign r_signal = r_q;
    assign error    = err_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer over three parameter sets.
// Latency: expectations are queued with the stimulus and checked 1 ns after the next edge.
// Backpressure: none; every step is a fixed single clock.
module tb_turn_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Index 0: LAMPS=3/TICK_DIV=1, 1: LAMPS=4/TICK_DIV=3, 2: LAMPS=3/TICK_DIV=2
    logic [2:0] rst_n, lft, rgt, haz, brk;

    logic [2:0] a_l, a_r;
    logic       a_e;
    logic [3:0] b_l, b_r;
    logic       b_e;
    logic [2:0] c_l, c_r;
    logic       c_e;

    turn_sequencer #(.LAMPS(3), .TICK_DIV(1)) dut_a (
        .clock(clock), .reset_n(rst_n[0]), .left(lft[0]), .right(rgt[0]),
        .hazard(haz[0]), .brake(brk[0]), .l_signal(a_l), .r_signal(a_r), .error(a_e)
    );

    turn_sequencer #(.LAMPS(4), .TICK_DIV(3)) dut_b (
        .clock(clock), .reset_n(rst_n[1]), .left(lft[1]), .right(rgt[1]),
        .hazard(haz[1]), .brake(brk[1]), .l_signal(b_l), .r_signal(b_r), .error(b_e)
    );

    turn_sequencer #(.LAMPS(3), .TICK_DIV(2)) dut_c (
        .clock(clock), .reset_n(rst_n[2]), .left(lft[2]), .right(rgt[2]),
        .hazard(haz[2]), .brake(brk[2]), .l_signal(c_l), .r_signal(c_r), .error(c_e)
    );

    typedef struct {
        int         which;
        logic [3:0] el;
        logic [3:0] er;
        logic       ee;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    function automatic logic [8:0] observe(input int which);
        logic [8:0] v;
        case (which)
            0:       v = {1'b0, a_l, 1'b0, a_r, a_e};
            1:       v = {b_l, b_r, b_e};
            default: v = {1'b0, c_l, 1'b0, c_r, c_e};
        endcase
        return v;
    endfunction

    task automatic drive(input int w, input logic l, input logic r,
                         input logic h, input logic b);
        lft[w] = l;
        rgt[w] = r;
        haz[w] = h;
        brk[w] = b;
    endtask

    task automatic expect_out(input int w, input logic [3:0] el, input logic [3:0] er,
                              input logic ee, input string tag);
        exp_t e;
        e.which = w;
        e.el    = el;
        e.er    = er;
        e.ee    = ee;
        e.tag   = tag;
        sb.push_back(e);
    endtask

    task automatic step_check();
        exp_t       e;
        logic [8:0] obs;
        logic [8:0] expv;
        @(posedge clock);
        #1;
        while (sb.size() > 0) begin
            e    = sb.pop_front();
            obs  = observe(e.which);
            expv = {e.el, e.er, e.ee};
            n_checks++;
            assert (obs === expv) n_pass++;
            else begin
                n_fail++;
                $error("FAIL %s dut%0d l/r/err observed=%h_%h_%b expected=%h_%h_%b",
                       e.tag, e.which, obs[8:5], obs[4:1], obs[0], e.el, e.er, e.ee);
            end
        end
    endtask

    task automatic cyc(input int w, input logic [3:0] el, input logic [3:0] er,
                       input logic ee, input string tag);
        expect_out(w, el, er, ee, tag);
        step_check();
    endtask

    initial begin
        logic [3:0] left_seq [9];
        logic [3:0] right_seq [5];
        logic [3:0] haz_seq [6];
        left_seq  = '{4'h1, 4'h3, 4'h7, 4'h0, 4'h1, 4'h3, 4'h7, 4'h0, 4'h1};
        right_seq = '{4'h8, 4'hC, 4'hE, 4'hF, 4'h0};
        haz_seq   = '{4'h7, 4'h7, 4'h0, 4'h0, 4'h7, 4'h7};

        rst_n = 3'b000;
        lft   = 3'b000;
        rgt   = 3'b000;
        haz   = 3'b000;
        brk   = 3'b000;

        // Reset state of every instance
        expect_out(0, 4'h0, 4'h0, 1'b0, "reset_a");
        expect_out(1, 4'h0, 4'h0, 1'b0, "reset_b");
        expect_out(2, 4'h0, 4'h0, 1'b0, "reset_c");
        step_check();
        rst_n = 3'b111;

        // Left fill, three lamps, one step per clock
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) cyc(0, left_seq[i], 4'h0, 1'b0, "left_seq");

        // Both switches lock out; only both low releases
        drive(0, 1, 1, 0, 0);
        cyc(0, 4'h0, 4'h0, 1'b1, "lock_enter");
        drive(0, 1, 0, 0, 0);
        cyc(0, 4'h0, 4'h0, 1'b1, "lock_hold_left");
        drive(0, 0, 0, 0, 0);
        cyc(0, 4'h0, 4'h0, 1'b0, "lock_exit");
        drive(0, 1, 0, 0, 0);
        cyc(0, 4'h1, 4'h0, 1'b0, "relock_left1");
        cyc(0, 4'h3, 4'h0, 1'b0, "relock_left2");

        // Reset mid-sequence, left held
        rst_n[0] = 1'b0;
        cyc(0, 4'h0, 4'h0, 1'b0, "mid_reset");
        rst_n[0] = 1'b1;
        cyc(0, 4'h1, 4'h0, 1'b0, "post_reset");

        // Brake overlay in idle and during a left turn
        drive(0, 0, 0, 0, 1);
        cyc(0, 4'h7, 4'h7, 1'b0, "brake_idle");
        drive(0, 1, 0, 0, 1);
        cyc(0, 4'h1, 4'h7, 1'b0, "brake_left1");
        cyc(0, 4'h3, 4'h7, 1'b0, "brake_left2");
        cyc(0, 4'h7, 4'h7, 1'b0, "brake_left3");
        cyc(0, 4'h0, 4'h7, 1'b0, "brake_left4");
        drive(0, 1, 0, 0, 0);
        cyc(0, 4'h1, 4'h0, 1'b0, "brake_release_keeps_step");

        // Direct left-to-right switch restarts at step 1
        drive(0, 0, 1, 0, 0);
        cyc(0, 4'h0, 4'h4, 1'b0, "left_to_right1");
        cyc(0, 4'h0, 4'h6, 1'b0, "left_to_right2");

        // Hazard outranks a turn switch
        drive(0, 0, 1, 1, 0);
        cyc(0, 4'h7, 4'h7, 1'b0, "haz_a_on");
        cyc(0, 4'h0, 4'h0, 1'b0, "haz_a_off");
        cyc(0, 4'h7, 4'h7, 1'b0, "haz_a_on2");

        // Lockout outranks hazard and ignores it while a turn switch stays high
        drive(0, 1, 1, 1, 0);
        cyc(0, 4'h0, 4'h0, 1'b1, "lock_over_haz");
        drive(0, 0, 1, 1, 0);
        cyc(0, 4'h0, 4'h0, 1'b1, "lock_haz_ignored");
        drive(0, 0, 0, 1, 0);
        cyc(0, 4'h7, 4'h7, 1'b0, "haz_after_lock");
        drive(0, 0, 0, 0, 0);

        // Right fill, four lamps, each step held three clocks
        drive(1, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 3; j++) cyc(1, 4'h0, right_seq[i], 1'b0, "right_div3");
        end
        cyc(1, 4'h0, 4'h8, 1'b0, "right_div3_wrap");

        // Hazard with a two-clock step; brake changes nothing
        drive(2, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) cyc(2, haz_seq[i], haz_seq[i], 1'b0, "haz_div2");
        drive(2, 0, 0, 1, 1);
        for (int i = 2; i < 6; i++) cyc(2, haz_seq[i], haz_seq[i], 1'b0, "haz_div2_brake");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
